// File: rtl/bs_term_accumulator.sv
// ============================================================================
// Module   : bs_term_accumulator
// Purpose  : Bit-serial shift/negate multiply-accumulate of power-of-two weight
//            terms into one signed dot-product result per term_last.
//            Optional macro BS_TERM_ACC_SAT_EN clamps on overflow instead of
//            wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bs_term_accumulator #(
   parameter int ACT_W = 8,
   parameter int ACC_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             term_valid,
   input  logic             term_last,
   input  logic             sign,
   input  logic [1:0]       exp,
   input  logic             mantissa,
   input  logic [2:0]       bsig,
   input  logic [ACT_W-1:0] act,
   output logic             busy,
   output logic             out_valid,
   output logic [ACC_W-1:0] result,
   output logic             ovf
);

   localparam int PW = ACT_W + 12;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ACCUM = 1'b1;

   logic [3:0]       shamt;
   logic [PW-1:0]    act_x;
   logic [PW-1:0]    shifted;
   logic [PW-1:0]    mag;
   logic [PW-1:0]    prod_d;

   logic [PW-1:0]    prod;
   logic             prod_vld;
   logic             prod_last;

   logic [ACC_W-1:0] acc;
   logic             ovf_acc;
   logic [ACC_W:0]   sum;
   logic             ovf_now;
   logic [ACC_W-1:0] new_val;

   logic [0:0]       state;
   logic [0:0]       next_state;

   // The 12 guard bits keep a 10-bit shift plus negation of the most
   // negative activation exact.
   assign shamt   = {2'b00, exp} + {1'b0, bsig};
   assign act_x   = {{12{act[ACT_W-1]}}, act};
   assign shifted = act_x << shamt;
   assign mag     = mantissa ? shifted : '0;
   assign prod_d  = sign ? -mag : mag;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prod      <= '0;
         prod_vld  <= 1'b0;
         prod_last <= 1'b0;
      end else if (clear) begin
         prod_vld  <= 1'b0;
         prod_last <= 1'b0;
      end else begin
         prod_vld <= term_valid;
         if (term_valid) begin
            prod      <= prod_d;
            prod_last <= term_last;
         end
      end
   end

   assign sum     = {acc[ACC_W-1], acc} + {{(ACC_W + 1 - PW){prod[PW-1]}}, prod};
   assign ovf_now = sum[ACC_W] ^ sum[ACC_W-1];

`ifdef BS_TERM_ACC_SAT_EN
   // Clamp direction follows the sign of the true (ACC_W+1)-bit sum.
   always_comb begin
      new_val = sum[ACC_W-1:0];
      if (ovf_now)
         new_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                              : {1'b0, {(ACC_W-1){1'b1}}};
   end
`else
   assign new_val = sum[ACC_W-1:0];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc       <= '0;
         ovf_acc   <= 1'b0;
         result    <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (clear) begin
            acc     <= '0;
            ovf_acc <= 1'b0;
         end else if (prod_vld) begin
            if (prod_last) begin
               result    <= new_val;
               ovf       <= ovf_acc | ovf_now;
               out_valid <= 1'b1;
               acc       <= '0;
               ovf_acc   <= 1'b0;
            end else begin
               acc     <= new_val;
               ovf_acc <= ovf_acc | ovf_now;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (clear)
         next_state = IDLE;
      else if (prod_vld)
         next_state = prod_last ? IDLE : ACCUM;
   end

   always_comb begin
      busy = (state == ACCUM) | prod_vld;
   end

endmodule

`default_nettype wire
